// File: rtl/home_auto_pkg.sv
// rtl/home_auto_pkg.sv - shared constants, types and helpers for the home event arbiter
//   Source indices FD..COOL (bit positions in pending and the one-hot actuator vector),
//   display codes, FSM state enum, temperature threshold defaults, and the
//   mapping between source indices and round-robin positions.
package home_auto_pkg;

  localparam logic [2:0] FD   = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] FIRE = 3'd2;
  localparam logic [2:0] WIN  = 3'd3;
  localparam logic [2:0] HEAT = 3'd4;
  localparam logic [2:0] COOL = 3'd5;

  localparam logic [2:0] DISP_IDLE   = 3'd0;
  localparam logic [2:0] DISP_FDOOR  = 3'd1;
  localparam logic [2:0] DISP_RDOOR  = 3'd2;
  localparam logic [2:0] DISP_FIRE   = 3'd3;
  localparam logic [2:0] DISP_WINDOW = 3'd4;
  localparam logic [2:0] DISP_HEATER = 3'd5;
  localparam logic [2:0] DISP_COOLER = 3'd6;

  localparam int unsigned T_LOW_DEFAULT  = 50;
  localparam int unsigned T_HIGH_DEFAULT = 70;

  // Number of sources sharing the round-robin (everything except fire).
  localparam int unsigned RR_N = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Round-robin position order is fd, rd, win, heat, cool.
  function automatic logic [2:0] rr_to_src(input logic [2:0] pos);
    case (pos)
      3'd0:    rr_to_src = FD;
      3'd1:    rr_to_src = RD;
      3'd2:    rr_to_src = WIN;
      3'd3:    rr_to_src = HEAT;
      default: rr_to_src = COOL;
    endcase
  endfunction

  function automatic logic [2:0] src_to_rr(input logic [2:0] src);
    case (src)
      FD:      src_to_rr = 3'd0;
      RD:      src_to_rr = 3'd1;
      WIN:     src_to_rr = 3'd2;
      HEAT:    src_to_rr = 3'd3;
      default: src_to_rr = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] disp_code(input logic [2:0] src);
    case (src)
      FD:      disp_code = DISP_FDOOR;
      RD:      disp_code = DISP_RDOOR;
      FIRE:    disp_code = DISP_FIRE;
      WIN:     disp_code = DISP_WINDOW;
      HEAT:    disp_code = DISP_HEATER;
      COOL:    disp_code = DISP_COOLER;
      default: disp_code = DISP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/home_event_arbiter_rr_pick5.sv
// rtl/home_event_arbiter_rr_pick5.sv - combinational round-robin picker over the five non-fire sources
//   pend  in  5  pending bits in round-robin position order (fd, rd, win, heat, cool)
//   ptr   in  3  position of the most recently served source
//   idx   out 3  position of the first pending source strictly after ptr (ptr itself last)
//   valid out 1  any bit of pend set
module rr_pick5
  import home_auto_pkg::*;
(
  input  logic [4:0] pend,
  input  logic [2:0] ptr,
  output logic [2:0] idx,
  output logic       valid
);

  logic [2:0] pos;

  always_comb begin
    idx   = 3'd0;
    valid = 1'b0;
    pos   = ptr;
    for (int i = 0; i < int'(RR_N); i++) begin
      pos = (pos == 3'(RR_N - 1)) ? 3'd0 : pos + 3'd1;
      if (!valid && pend[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/home_event_arbiter.sv
// rtl/home_event_arbiter.sv - demand-driven arbiter sharing one actuator/display path among six home event sources
//   Clk, Rst (sync, active-high)
//   SFD, SRD, SW, SFA   level sensor inputs; ST 7-bit unsigned temperature; Ack ends a grant early
//   fdoor, rdoor, alarmbuzz, winbuzz, heater, cooler   registered one-hot-or-zero actuator drives
//   display (3)  code of the granted source, 0 when idle
//   pending (6)  sticky requests {cool, heat, win, fire, rd, fd} from bit 5 down to bit 0
//   busy         high while a grant is being served
//   Build option FIRE_LATCH_EN: fire grant holds until Ack and its pending bit clears only via Ack.
module home_event_arbiter
  import home_auto_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned T_LOW       = T_LOW_DEFAULT,
  parameter int unsigned T_HIGH      = T_HIGH_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SW,
  input  logic       SFA,
  input  logic [6:0] ST,
  input  logic       Ack,
  output logic       fdoor,
  output logic       rdoor,
  output logic       alarmbuzz,
  output logic       winbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic [5:0] pending,
  output logic       busy
);

  localparam logic [7:0] HOLD_M1  = 8'(HOLD_CYCLES - 1);
  localparam logic [6:0] T_LOW_V  = 7'(T_LOW);
  localparam logic [6:0] T_HIGH_V = 7'(T_HIGH);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;       // round-robin position of the last completed non-fire grant
  logic [2:0] cur_q, cur_d;       // source index currently granted
  logic [5:0] pending_q, pending_d;
  logic [5:0] act_q, act_d;
  logic [2:0] disp_q, disp_d;

  logic [5:0] req;
  logic [5:0] clr;
  logic       done;
  logic [4:0] rr_pend;
  logic [2:0] pick_idx;
  logic       pick_valid;

  assign req = {(ST > T_HIGH_V), (ST < T_LOW_V), SW, SFA, SRD, SFD};

  assign rr_pend = {pending_q[COOL], pending_q[HEAT], pending_q[WIN],
                    pending_q[RD], pending_q[FD]};

  rr_pick5 u_rr_pick5 (
    .pend  (rr_pend),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      ptr_q     <= 3'd0;
      cur_q     <= FD;
      pending_q <= 6'd0;
      act_q     <= 6'd0;
      disp_q    <= DISP_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      act_q     <= act_d;
      disp_q    <= disp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    clr     = 6'd0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q[FIRE]) begin
          state_d = SERVE;
          cnt_d   = HOLD_M1;
          cur_d   = FIRE;
        end else if (pick_valid) begin
          state_d = SERVE;
          cnt_d   = HOLD_M1;
          cur_d   = rr_to_src(pick_idx);
        end
      end
      SERVE: begin
        done = Ack || (cnt_q == 8'd0);
`ifdef FIRE_LATCH_EN
        if (cur_q == FIRE) begin
          done = Ack;
        end
`endif
        // A grant that is ending on this edge completes normally even if fire
        // has just become pending; fire is then picked up from IDLE.
        if (done) begin
          clr[cur_q] = 1'b1;
          if (cur_q != FIRE) begin
            ptr_d = src_to_rr(cur_q);
          end
          state_d = GAP;
        end else if (pending_q[FIRE] && (cur_q != FIRE)) begin
          cur_d = FIRE;
          cnt_d = HOLD_M1;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // New requests win over a clear on the same edge.
    pending_d = (pending_q & ~clr) | req;
  end

  // Output logic, registered alongside the state
  always_comb begin
    act_d  = 6'd0;
    disp_d = DISP_IDLE;
    if (state_d == SERVE) begin
      act_d[cur_d] = 1'b1;
      disp_d       = disp_code(cur_d);
    end
  end

  assign fdoor     = act_q[FD];
  assign rdoor     = act_q[RD];
  assign alarmbuzz = act_q[FIRE];
  assign winbuzz   = act_q[WIN];
  assign heater    = act_q[HEAT];
  assign cooler    = act_q[COOL];
  assign display   = disp_q;
  assign pending   = pending_q;
  assign busy      = (state_q == SERVE);

endmodule
